serial_word_receiver: RTL and testbench

Framed serial-to-parallel receiver that produces the 8-bit word and load/clear strobes consumed by the downstream 8-bit load/clear register. It oversamples a single asynchronous serial line with start bit, 8 data bits (LSB first) and stop bit. It emits a one-cycle load strobe with the received byte, a clear strobe on a line break, or an error strobe on a bad stop bit. It sits between the serial pin and the register's load/clear/data inputs.

---
 rtl/serial_word_receiver.sv | 113 +++++++++++
 tb/tb_serial_word_receiver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: oversampling 8N1 receiver that feeds the downstream
// 8-bit load/clear register. It emits a load strobe with each good byte, a
// clear strobe on a line break, and a frame-error strobe on a bad stop bit.
module serial_word_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       in_serial,
    output logic [7:0] out_data,
    output logic       out_load,
    output logic       out_clear,
    output logic       out_frame_err,
    output logic       out_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic          sync_q;
    logic          line;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q <= 1'b1;
            line   <= 1'b1;
        end else begin
            sync_q <= in_serial;
            line   <= sync_q;
        end
    end

    // Frame FSM: mid-bit sampling, shift-in LSB first, registered strobes.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= '0;
            sh            <= '0;
            out_data      <= '0;
            out_load      <= 1'b0;
            out_clear     <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            out_load      <= 1'b0;
            out_clear     <= 1'b0;
            out_frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!line) state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        // A start bit that is gone by mid-bit was a glitch.
                        state <= line ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        sh  <= {line, sh[7:1]};
                        idx <= idx + 1'b1;
                        if (idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (line) begin
                            out_data <= sh;
                            out_load <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            // All-zero data plus low stop bit means break.
                            if (sh == 8'h00) out_clear     <= 1'b1;
                            else             out_frame_err <= 1'b1;
                            state <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (line) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Busy follows the registered state directly.
    assign out_busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench: the driver pushes the expected strobe for each frame it
// sends (derived from the frame contents alone); a monitor pops and compares
// whenever the receiver raises a strobe, and checks latency and data hold.
module tb_serial_word_receiver;

    localparam int N       = 16;
    localparam int LAT     = 2 + 1 + N / 2 + 9 * N;
    localparam int K_LOAD  = 0;
    localparam int K_CLEAR = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       in_serial = 1'b1;
    logic [7:0] out_data;
    logic       out_load, out_clear, out_frame_err, out_busy;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] mdl_last = 8'h00;  // last byte the model says was loaded
    logic [7:0] cur = 8'h00;       // value out_data must hold between loads

    serial_word_receiver #(.CLKS_PER_BIT(N)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .in_serial    (in_serial),
        .out_data     (out_data),
        .out_load     (out_load),
        .out_clear    (out_clear),
        .out_frame_err(out_frame_err),
        .out_busy     (out_busy)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    // Drive a level for n bit-clock cycles; caller sits just after a posedge.
    task automatic drive(input logic v, input int n);
        in_serial = v;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Send one frame; stop level held for stop_bits bit times.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_bits);
        exp_t e;
        e.t = cyc;
        if (stop) begin
            e.kind = K_LOAD;
            e.data = d;
            mdl_last = d;
        end else begin
            e.kind = (d == 8'h00) ? K_CLEAR : K_ERR;
            e.data = mdl_last;
        end
        sb.push_back(e);
        drive(1'b0, N);
        for (int b = 0; b < 8; b++) drive(d[b], N);
        drive(stop, N * stop_bits);
        in_serial = 1'b1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every strobe against the scoreboard head.
    always @(negedge clk_in) begin
        exp_t e;
        int   nstb;
        int   kind;
        if (!rst_n_in) begin
            cur = 8'h00;
        end else begin
            nstb = int'(out_load) + int'(out_clear) + int'(out_frame_err);
            if (nstb > 0) begin
                chk("strobe_exclusive", int'(nstb > 1), 0);
                kind = out_load ? K_LOAD : (out_clear ? K_CLEAR : K_ERR);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe_kind", kind, -1);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind", kind, e.kind);
                    chk("strobe_data", int'(out_data), int'(e.data));
                    total++;
                    if (cyc - e.t < LAT - 1 || cyc - e.t > LAT + 1) begin
                        bad++;
                        $display("FAIL latency: got %0d expected %0d+-1", cyc - e.t, LAT);
                    end
                    if (e.kind == K_LOAD) cur = e.data;
                end
            end else begin
                chk("data_hold", int'(out_data), int'(cur));
            end
        end
    end

    initial begin
        int r, g;
        logic [7:0] d;

        // Reset held with a toggling line: everything must stay at reset values.
        for (int i = 0; i < 6; i++) begin
            in_serial = i[0];
            repeat (3) @(posedge clk_in);
            #1;
            chk("rst_data", int'(out_data), 0);
            chk("rst_strobes", int'({out_load, out_clear, out_frame_err}), 0);
            chk("rst_busy", int'(out_busy), 0);
        end
        in_serial = 1'b1;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        drive(1'b1, 200);
        chk("idle_busy", int'(out_busy), 0);

        // Single frame.
        send_frame(8'hA5, 1'b1, 1);
        drive(1'b1, 4);
        // Back-to-back with one-bit stops.
        send_frame(8'h01, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);
        send_frame(8'h80, 1'b1, 1);
        drive(1'b1, 4);

        // Glitch then a real frame.
        drive(1'b0, 4);
        drive(1'b1, 20);
        chk("glitch_idle_busy", int'(out_busy), 0);
        send_frame(8'h3C, 1'b1, 1);
        drive(1'b1, 16);

        // Break: 30 bit times low.
        send_frame(8'h00, 1'b0, 21);
        drive(1'b1, 32);
        send_frame(8'h55, 1'b1, 1);
        drive(1'b1, 16);

        // Frame error with a two-bit low stop.
        send_frame(8'h12, 1'b0, 2);
        drive(1'b1, 32);

        // Reset in the middle of the next frame: no strobe, outputs reset.
        drive(1'b0, N);
        for (int b = 0; b < 4; b++) drive(b[0], N);
        rst_n_in = 1'b0;
        mdl_last = 8'h00;
        #1;
        chk("midrst_busy", int'(out_busy), 0);
        chk("midrst_data", int'(out_data), 0);
        in_serial = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        drive(1'b1, 8);
        send_frame(8'h99, 1'b1, 1);
        drive(1'b1, 4);

        // Randomized mix of good frames, glitches and bad stops.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom_range(0, 255));
            if (r < 7) begin
                send_frame(d, 1'b1, 1);
                g = $urandom_range(0, 20);
                if (g > 0) drive(1'b1, g);
            end else if (r == 7) begin
                drive(1'b0, $urandom_range(1, 5));
                drive(1'b1, 14);
            end else begin
                send_frame(d, 1'b0, $urandom_range(1, 3));
                drive(1'b1, N + $urandom_range(0, 10));
            end
        end

        drive(1'b1, 3 * N);
        chk("scoreboard_empty", sb.size(), 0);
        chk("final_busy", int'(out_busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
